keypad_row_scanner: RTL and testbench
=====================================

Name: keypad_row_scanner

Overview:
- Active scanning side of the 5x4 matrix keypad: drives K_ROW one row at a time and samples K_COL.
- Debounces per key and emits a key code, a one-cycle press pulse and a held level.
- Replaces static row drive from switches; outputs feed the same downstream consumers as the button conditioner (display/ALU control logic).

Parameters:
- SCAN_DIV, 50000, clk cycles each row is driven (dwell); must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive matching dwell samples needed to accept a press or a release; must be >= 1.
- REPEAT_DELAY, 200, dwell ticks held before the first auto-repeat (used only with KEY_REPEAT_EN).
- REPEAT_RATE, 40, dwell ticks between auto-repeats (used only with KEY_REPEAT_EN).

Ports:
- clk  input  1  system clock
- RSTN  input  1  asynchronous, active-low reset
- K_COL  input  4  keypad column lines, active low (0 = key in the driven row pressed)
- K_ROW  output  5  keypad row drive, one-hot low (0 = row driven)
- key_code  output  5  last accepted key, row*4 + col, range 0..19
- key_valid  output  1  one-cycle pulse when key_code is updated or repeated
- key_down  output  1  high while the accepted key is held
- multi_key  output  1  high if more than one column was low at the last accepting sample

Behaviour:
- Reset (RSTN=0, async):
  - K_ROW=5'b11110 (row 0); key_code=0; key_valid=0; key_down=0; multi_key=0.
  - Dwell counter=0; FSM=SCAN; all debounce and repeat counters=0.
  - Synchronizer flops=4'b1111.
- Synchronizing K_COL: two-flop synchronizer. colS is the synchronized value.
- Dwell timing:
  - Counter runs 0..SCAN_DIV-1 and wraps.
  - Tick = cycle with counter==SCAN_DIV-1. colS is sampled only on a tick, which gives SCAN_DIV-2 cycles of settle plus sync.
- Row rotation (SCAN state only): on each tick, K_ROW rotates to the next row, 0->1->2->3->4->0.
- Column decode: lowest-index low bit of colS; ties give lowest column. multi_key = (count of low bits > 1), updated only when a press is accepted.
- FSM:
  - SCAN: on a tick with colS != 4'hF:
    - Lock the current row (no rotation), store candidate col, deb=1, go DEBOUNCE.
    - If DEBOUNCE_SCANS==1, accept immediately (see accept below).
  - DEBOUNCE, on each tick:
    - Same candidate col low: deb++.
    - When deb reaches DEBOUNCE_SCANS, accept: key_code=row*4+col, key_valid=1 for one cycle, key_down=1, go HELD.
    - Candidate col high: go SCAN, row advances on that tick.
  - HELD, on each tick:
    - Candidate col high: rel++.
    - Candidate col low: rel=0.
    - When rel reaches DEBOUNCE_SCANS: key_down=0, go SCAN, row advances. key_code keeps its value.
    - Other columns of the locked row are ignored while HELD.
- Latency: press visible on colS -> key_valid occurs on the DEBOUNCE_SCANS-th tick that samples it.
- key_valid is never high on two consecutive cycles.
- Reset mid-operation: every state is abandoned immediately, with no pulse emitted.

Optional Feature:
- KEY_REPEAT_EN defined:
  - In HELD, a repeat counter increments each tick while the key stays low. It is cleared when the key is released or when HELD is entered.
  - On reaching REPEAT_DELAY: key_valid pulses with the same key_code. After that, it pulses every REPEAT_RATE ticks.
- KEY_REPEAT_EN undefined: no repeat logic; exactly one key_valid per accepted press.

Test Plan:
- Test parameters: SCAN_DIV=8, DEBOUNCE_SCANS=3, REPEAT_DELAY=4, REPEAT_RATE=2. Keypad model pulls K_COL[c] low while K_ROW[r]=0 and key (r,c) is pressed.
- Reset then idle 100 cycles:
  - K_ROW cycles 11110,11101,11011,10111,01111, changing every 8 cycles.
  - key_valid never asserts; all outputs at reset values.
- Hold key (2,1) steady:
  - Row locks at 11011.
  - Exactly one key_valid pulse with key_code=9 on the 3rd matching tick; key_down=1, multi_key=0.
  - Release: key_down falls after 3 released ticks, then rotation resumes at row 3.
- Bounce: key (4,3) pressed for 2 ticks then released -> no key_valid; scanning resumes. Then held for 3 ticks -> key_code=19.
- Keys (1,0) and (1,2) held together -> key_code=4, multi_key=1; releasing (1,2) only does not release the key.
- RSTN pulsed low while in DEBOUNCE -> outputs return to reset values immediately; no key_valid emitted.
- With KEY_REPEAT_EN, hold key (0,0) for 12 ticks -> key_valid pulses on the accept tick, then 4 ticks later, then every 2 ticks; key_code=0 on each pulse.

Source files
------------

// File: rtl/keypad_row_scanner.sv
// keypad_row_scanner
// ------------------
// Active row scanner for a 5x4 matrix keypad. Rows are driven low one at a
// time for SCAN_DIV clock cycles each; the (synchronized) column lines are
// sampled once at the end of every dwell period ("tick"). A detected key
// locks the row, is debounced over DEBOUNCE_SCANS ticks, and is then reported
// as a key code with a one-cycle valid pulse and a held level. Release is
// debounced over the same number of ticks before scanning resumes.
//
// Optional feature: define KEY_REPEAT_EN to enable auto-repeat. While a key is
// held, key_valid pulses again after REPEAT_DELAY ticks and then every
// REPEAT_RATE ticks. Without the macro, exactly one pulse is emitted per press.
//
// Parameters:
//   SCAN_DIV        clk cycles each row is driven (>= 4)
//   DEBOUNCE_SCANS  matching tick samples to accept a press or release (>= 1)
//   REPEAT_DELAY    ticks held before the first repeat (KEY_REPEAT_EN only)
//   REPEAT_RATE     ticks between repeats (KEY_REPEAT_EN only)
//
// Ports:
//   clk        system clock
//   RSTN       asynchronous active-low reset
//   K_COL[3:0] column lines, active low
//   K_ROW[4:0] row drive, one-hot low
//   key_code   last accepted key, row*4 + col (0..19)
//   key_valid  one-cycle pulse on accept (and on repeat)
//   key_down   high while the accepted key is held
//   multi_key  more than one column was low when the key was accepted

module keypad_row_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 200,
  parameter int REPEAT_RATE    = 40
) (
  input  logic       clk,
  input  logic       RSTN,
  input  logic [3:0] K_COL,
  output logic [4:0] K_ROW,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       multi_key
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);

  // Parameter sanity checks at elaboration time.
  generate
    if (SCAN_DIV < 4) begin : g_bad_scan_div
      $error("keypad_row_scanner: SCAN_DIV must be >= 4");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
      $error("keypad_row_scanner: DEBOUNCE_SCANS must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
      $error("keypad_row_scanner: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [3:0]       col_meta_reg;
  logic [3:0]       col_sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       row_idx_reg, row_idx_next;
  logic [4:0]       row_drive_reg, row_drive_next;
  state_t           state_reg, state_next;
  logic [1:0]       cand_col_reg, cand_col_next;
  logic [DEB_W-1:0] deb_cnt_reg, deb_cnt_next;
  logic [DEB_W-1:0] rel_cnt_reg, rel_cnt_next;
  logic [4:0]       key_code_reg, key_code_next;
  logic             key_valid_reg, key_valid_next;
  logic             key_down_reg, key_down_next;
  logic             multi_key_reg, multi_key_next;

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
  // Cleared until the first repeat fires; afterwards the interval is REPEAT_RATE.
  logic             rep_armed_reg, rep_armed_next;
`endif

  // ---------------------------------------------------------------------------
  // Column decode of the synchronized sample
  // ---------------------------------------------------------------------------
  logic       tick;
  logic [3:0] col_low;
  logic       any_low;
  logic [1:0] first_col;
  logic [2:0] low_count;
  logic       cand_low;

  assign tick = (cnt_reg == CNT_W'(SCAN_DIV - 1));

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col_low
      assign col_low[gi] = ~col_sync_reg[gi];
    end
  endgenerate

  assign any_low  = |col_low;
  assign cand_low = col_low[cand_col_reg];

  // Lowest-index low column wins when several are low.
  always_comb begin
    first_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (col_low[i]) first_col = 2'(i);
    end
  end

  always_comb begin
    low_count = 3'd0;
    for (int i = 0; i < 4; i++) begin
      low_count = low_count + {2'b00, col_low[i]};
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. All decisions are taken on a tick only.
  // ---------------------------------------------------------------------------
  logic       accept;
  logic [1:0] accept_col;
  logic       advance;

  always_comb begin
    state_next     = state_reg;
    row_idx_next   = row_idx_reg;
    row_drive_next = row_drive_reg;
    cand_col_next  = cand_col_reg;
    deb_cnt_next   = deb_cnt_reg;
    rel_cnt_next   = rel_cnt_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_down_next  = key_down_reg;
    multi_key_next = multi_key_reg;
`ifdef KEY_REPEAT_EN
    rep_cnt_next   = rep_cnt_reg;
    rep_armed_next = rep_armed_reg;
`endif
    accept     = 1'b0;
    accept_col = cand_col_reg;
    advance    = 1'b0;

    if (tick) begin
      unique case (state_reg)
        ST_SCAN: begin
          if (any_low) begin
            // Lock on this row; the candidate column is tracked from now on.
            cand_col_next = first_col;
            deb_cnt_next  = DEB_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              accept     = 1'b1;
              accept_col = first_col;
            end else begin
              state_next = ST_DEBOUNCE;
            end
          end else begin
            advance = 1'b1;
          end
        end

        ST_DEBOUNCE: begin
          if (cand_low) begin
            deb_cnt_next = deb_cnt_reg + DEB_W'(1);
            if (int'(deb_cnt_reg) + 1 >= DEBOUNCE_SCANS) accept = 1'b1;
          end else begin
            // Bounce: abandon the candidate and move on to the next row.
            state_next   = ST_SCAN;
            deb_cnt_next = '0;
            advance      = 1'b1;
          end
        end

        ST_HELD: begin
          // Only the candidate column matters; other keys on the row are ignored.
          if (!cand_low) begin
            if (int'(rel_cnt_reg) + 1 >= DEBOUNCE_SCANS) begin
              key_down_next = 1'b0;
              state_next    = ST_SCAN;
              rel_cnt_next  = '0;
              advance       = 1'b1;
            end else begin
              rel_cnt_next = rel_cnt_reg + DEB_W'(1);
            end
`ifdef KEY_REPEAT_EN
            rep_cnt_next   = '0;
            rep_armed_next = 1'b0;
`endif
          end else begin
            rel_cnt_next = '0;
`ifdef KEY_REPEAT_EN
            if (!rep_armed_reg) begin
              if (int'(rep_cnt_reg) + 1 >= REPEAT_DELAY) begin
                key_valid_next = 1'b1;
                rep_cnt_next   = '0;
                rep_armed_next = 1'b1;
              end else begin
                rep_cnt_next = rep_cnt_reg + REP_W'(1);
              end
            end else begin
              if (int'(rep_cnt_reg) + 1 >= REPEAT_RATE) begin
                key_valid_next = 1'b1;
                rep_cnt_next   = '0;
              end else begin
                rep_cnt_next = rep_cnt_reg + REP_W'(1);
              end
            end
`endif
          end
        end

        default: begin
          state_next = ST_SCAN;
        end
      endcase
    end

    if (advance) begin
      row_idx_next   = (row_idx_reg == 3'd4) ? 3'd0 : row_idx_reg + 3'd1;
      row_drive_next = {row_drive_reg[3:0], row_drive_reg[4]};
    end

    if (accept) begin
      // row*4 + col is simply the row index concatenated with the column.
      key_code_next  = {row_idx_reg, accept_col};
      key_valid_next = 1'b1;
      key_down_next  = 1'b1;
      multi_key_next = (low_count > 3'd1);
      state_next     = ST_HELD;
      deb_cnt_next   = '0;
      rel_cnt_next   = '0;
`ifdef KEY_REPEAT_EN
      rep_cnt_next   = '0;
      rep_armed_next = 1'b0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      col_meta_reg  <= 4'hF;
      col_sync_reg  <= 4'hF;
      cnt_reg       <= '0;
      row_idx_reg   <= 3'd0;
      row_drive_reg <= 5'b11110;
      state_reg     <= ST_SCAN;
      cand_col_reg  <= 2'd0;
      deb_cnt_reg   <= '0;
      rel_cnt_reg   <= '0;
      key_code_reg  <= 5'd0;
      key_valid_reg <= 1'b0;
      key_down_reg  <= 1'b0;
      multi_key_reg <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_reg   <= '0;
      rep_armed_reg <= 1'b0;
`endif
    end else begin
      col_meta_reg  <= K_COL;
      col_sync_reg  <= col_meta_reg;
      cnt_reg       <= tick ? '0 : cnt_reg + CNT_W'(1);
      row_idx_reg   <= row_idx_next;
      row_drive_reg <= row_drive_next;
      state_reg     <= state_next;
      cand_col_reg  <= cand_col_next;
      deb_cnt_reg   <= deb_cnt_next;
      rel_cnt_reg   <= rel_cnt_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_down_reg  <= key_down_next;
      multi_key_reg <= multi_key_next;
`ifdef KEY_REPEAT_EN
      rep_cnt_reg   <= rep_cnt_next;
      rep_armed_reg <= rep_armed_next;
`endif
    end
  end

  assign K_ROW     = row_drive_reg;
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_down  = key_down_reg;
  assign multi_key = multi_key_reg;

endmodule

// File: tb/tb_keypad_row_scanner.sv
// Directed testbench for keypad_row_scanner with SCAN_DIV=8, DEBOUNCE_SCANS=3,
// REPEAT_DELAY=4, REPEAT_RATE=2. A keypad model pulls a column low while its
// row is driven and the key is pressed. Cycle index k counts rising edges since
// the last reset release; outputs are sampled on the falling edge after edge k.
// Ticks (column samples) fall on edges k = 8, 16, 24, ...

module tb_keypad_row_scanner;

  logic       clk;
  logic       RSTN;
  logic [3:0] K_COL;
  logic [4:0] K_ROW;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       multi_key;

  logic [19:0] pressed;
  int          k;
  int          checks;
  int          failures;
  int          pulse_cnt;
  int          base_cnt;

  keypad_row_scanner #(
    .SCAN_DIV      (8),
    .DEBOUNCE_SCANS(3),
    .REPEAT_DELAY  (4),
    .REPEAT_RATE   (2)
  ) dut (
    .clk      (clk),
    .RSTN     (RSTN),
    .K_COL    (K_COL),
    .K_ROW    (K_ROW),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down),
    .multi_key(multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model.
  always_comb begin
    K_COL = 4'hF;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!K_ROW[r] && pressed[r*4 + c]) K_COL[c] = 1'b0;
      end
    end
  end

  // Count key_valid pulses.
  always @(negedge clk) begin
    if (key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    RSTN = 1'b0;
    repeat (3) @(negedge clk);
    RSTN = 1'b1;
    k = 0;
  endtask

  function automatic logic [4:0] row_drive(input int r);
    logic [4:0] v;
    v = 5'b11111;
    v[r] = 1'b0;
    return v;
  endfunction

  int rep_ks[6] = '{24, 56, 72, 88, 104, 120};

  initial begin
    checks    = 0;
    failures  = 0;
    pulse_cnt = 0;
    pressed   = '0;
    k         = 0;
    RSTN      = 1'b0;

    // ---- Reset values --------------------------------------------------
    repeat (3) @(negedge clk);
    chk("rst_k_row", 32'(K_ROW), 32'(5'b11110));
    chk("rst_key_code", 32'(key_code), 32'd0);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_key_down", 32'(key_down), 32'd0);
    chk("rst_multi_key", 32'(multi_key), 32'd0);
    $display("reset: K_ROW=%b key_code=%0d", K_ROW, key_code);

    // ---- Idle scanning: row changes every 8 cycles ---------------------
    RSTN = 1'b1;
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      chk("idle_k_row", 32'(K_ROW), 32'(row_drive((k / 8) % 5)));
      chk("idle_key_valid", 32'(key_valid), 32'd0);
    end
    chk("idle_key_down", 32'(key_down), 32'd0);
    chk("idle_key_code", 32'(key_code), 32'd0);
    chk("idle_pulses", 32'(pulse_cnt), 32'd0);
    $display("idle: 100 cycles, K_ROW=%b pulses=%0d", K_ROW, pulse_cnt);

    // ---- Hold key (2,1) ------------------------------------------------
    do_reset();
    base_cnt = pulse_cnt;
    pressed[2*4 + 1] = 1'b1;
    run_to(39);
    chk("k21_locked_row", 32'(K_ROW), 32'(5'b11011));
    chk("k21_no_early_pulse", 32'(pulse_cnt - base_cnt), 32'd0);
    chk("k21_pre_valid", 32'(key_valid), 32'd0);
    step();
    chk("k21_valid", 32'(key_valid), 32'd1);
    chk("k21_code", 32'(key_code), 32'd9);
    chk("k21_down", 32'(key_down), 32'd1);
    chk("k21_multi", 32'(multi_key), 32'd0);
    $display("press (2,1): k=%0d key_code=%0d key_down=%b", k, key_code, key_down);
    step();
    chk("k21_valid_one_cycle", 32'(key_valid), 32'd0);
    run_to(56);
    chk("k21_held_down", 32'(key_down), 32'd1);
    chk("k21_held_row", 32'(K_ROW), 32'(5'b11011));
    pressed = '0;
    run_to(79);
    chk("k21_release_pending", 32'(key_down), 32'd1);
    step();
    chk("k21_released", 32'(key_down), 32'd0);
    chk("k21_resume_row3", 32'(K_ROW), 32'(5'b10111));
    chk("k21_code_kept", 32'(key_code), 32'd9);
    run_to(88);
    chk("k21_next_row4", 32'(K_ROW), 32'(5'b01111));
    chk("k21_single_pulse", 32'(pulse_cnt - base_cnt), 32'd1);
    $display("release (2,1): k=%0d K_ROW=%b pulses=%0d", k, K_ROW, pulse_cnt - base_cnt);

    // ---- Bounce on key (4,3), then a proper press ----------------------
    do_reset();
    base_cnt = pulse_cnt;
    pressed[4*4 + 3] = 1'b1;
    run_to(48);
    chk("bounce_locked", 32'(K_ROW), 32'(5'b01111));
    pressed = '0;
    run_to(56);
    chk("bounce_resume_row0", 32'(K_ROW), 32'(5'b11110));
    chk("bounce_no_pulse", 32'(pulse_cnt - base_cnt), 32'd0);
    chk("bounce_no_down", 32'(key_down), 32'd0);
    $display("bounce (4,3): k=%0d K_ROW=%b pulses=%0d", k, K_ROW, pulse_cnt - base_cnt);
    pressed[4*4 + 3] = 1'b1;
    run_to(111);
    chk("k43_no_early_pulse", 32'(pulse_cnt - base_cnt), 32'd0);
    step();
    chk("k43_valid", 32'(key_valid), 32'd1);
    chk("k43_code", 32'(key_code), 32'd19);
    chk("k43_multi", 32'(multi_key), 32'd0);
    $display("press (4,3): k=%0d key_code=%0d", k, key_code);
    pressed = '0;

    // ---- Two keys on row 1: (1,0) and (1,2) ----------------------------
    do_reset();
    base_cnt = pulse_cnt;
    pressed[1*4 + 0] = 1'b1;
    pressed[1*4 + 2] = 1'b1;
    run_to(32);
    chk("multi_valid", 32'(key_valid), 32'd1);
    chk("multi_code", 32'(key_code), 32'd4);
    chk("multi_flag", 32'(multi_key), 32'd1);
    $display("press (1,0)+(1,2): key_code=%0d multi_key=%b", key_code, multi_key);
    run_to(40);
    pressed[1*4 + 2] = 1'b0;
    run_to(56);
    chk("multi_still_down", 32'(key_down), 32'd1);
    chk("multi_row_locked", 32'(K_ROW), 32'(5'b11101));
    chk("multi_one_pulse", 32'(pulse_cnt - base_cnt), 32'd1);
    pressed = '0;
    run_to(80);
    chk("multi_released", 32'(key_down), 32'd0);
    chk("multi_resume_row2", 32'(K_ROW), 32'(5'b11011));
    chk("multi_flag_kept", 32'(multi_key), 32'd1);
    chk("multi_code_kept", 32'(key_code), 32'd4);
    $display("release row 1: K_ROW=%b key_code=%0d", K_ROW, key_code);

    // ---- Reset while debouncing (2,1) ----------------------------------
    base_cnt = pulse_cnt;
    pressed[2*4 + 1] = 1'b1;
    run_to(92);
    chk("rstdeb_locked", 32'(K_ROW), 32'(5'b11011));
    RSTN = 1'b0;
    #1;
    chk("rstdeb_k_row", 32'(K_ROW), 32'(5'b11110));
    chk("rstdeb_code", 32'(key_code), 32'd0);
    chk("rstdeb_multi", 32'(multi_key), 32'd0);
    chk("rstdeb_down", 32'(key_down), 32'd0);
    chk("rstdeb_valid", 32'(key_valid), 32'd0);
    pressed = '0;
    repeat (3) @(negedge clk);
    RSTN = 1'b1;
    k = 0;
    run_to(40);
    chk("rstdeb_no_pulse", 32'(pulse_cnt - base_cnt), 32'd0);
    $display("reset in debounce: K_ROW=%b pulses=%0d", K_ROW, pulse_cnt - base_cnt);

    // ---- Long hold of key (0,0) ----------------------------------------
    do_reset();
    base_cnt = pulse_cnt;
    pressed[0] = 1'b1;
    run_to(23);
    chk("hold00_pre_valid", 32'(key_valid), 32'd0);
`ifdef KEY_REPEAT_EN
    for (int i = 0; i < 6; i++) begin
      run_to(rep_ks[i]);
      chk("repeat_valid", 32'(key_valid), 32'd1);
      chk("repeat_code", 32'(key_code), 32'd0);
      $display("repeat pulse at k=%0d key_code=%0d", k, key_code);
    end
    step();
    chk("repeat_total", 32'(pulse_cnt - base_cnt), 32'd6);
`else
    run_to(rep_ks[0]);
    chk("hold00_valid", 32'(key_valid), 32'd1);
    chk("hold00_code", 32'(key_code), 32'd0);
    run_to(121);
    chk("hold00_single_pulse", 32'(pulse_cnt - base_cnt), 32'd1);
    chk("hold00_down", 32'(key_down), 32'd1);
    $display("hold (0,0): pulses=%0d key_down=%b", pulse_cnt - base_cnt, key_down);
`endif
    pressed = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
